// File: rtl/paquete_datapath.sv
// Shared types and constants for the instruction fetch stage.
package paquete_datapath;

  typedef enum logic [1:0] {
    INICIO    = 2'd0,
    PEDIR     = 2'd1,
    DESCARTAR = 2'd2,
    ENTREGA   = 2'd3
  } estado_t;

  localparam int ANCHO   = 32;
  localparam int PC_INCR = 4;

endpackage

// File: rtl/registro_pc.sv
// Program counter: word-aligned redirect mux, +4 adder and the PC register.
module registro_pc #(
  parameter int               ANCHO    = paquete_datapath::ANCHO,
  parameter logic [ANCHO-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             salto_valido,
  input  logic [ANCHO-1:0] salto_destino,
  input  logic             incrementar,
  output logic [ANCHO-1:0] pc,
  output logic [ANCHO-1:0] pc_inc,
  output logic [ANCHO-1:0] pc_siguiente
);
  import paquete_datapath::*;

  logic [ANCHO-1:0] destino_alineado;

  // Arithmetic wraps naturally at 2^ANCHO.
  assign pc_inc           = pc + ANCHO'(PC_INCR);
  assign destino_alineado = salto_destino & ~ANCHO'(3);

  always_comb begin
    pc_siguiente = pc;
    if (salto_valido)
      pc_siguiente = destino_alineado;
    else if (incrementar)
      pc_siguiente = pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= pc_siguiente;
  end

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction fetch stage: one outstanding memory request, one instruction
// handed to the downstream buffer at a time, with redirect and stall support.
//
// state     | meaning
// INICIO    | one idle cycle after reset, no request
// PEDIR     | request at imem_addr outstanding, waiting for ack
// DESCARTAR | request outstanding but redirected; its data will be dropped
// ENTREGA   | instruction presented (valido=1), waiting for stall to drop
module etapa_busqueda #(
  parameter int               ANCHO    = paquete_datapath::ANCHO,
  parameter logic [ANCHO-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             salto_valido,
  input  logic [ANCHO-1:0] salto_destino,
  output logic             imem_req,
  output logic [ANCHO-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [ANCHO-1:0] imem_dato,
  output logic [ANCHO-1:0] instr,
  output logic [ANCHO-1:0] pc_out,
  output logic [ANCHO-1:0] pc_mas4,
  output logic             valido
);
  import paquete_datapath::*;

  estado_t          estado, estado_sig;
  logic             incrementar;
  logic             capturar;
  logic             cargar_addr;
  logic             limpiar_valido;
  logic [ANCHO-1:0] pc;
  logic [ANCHO-1:0] pc_inc;
  logic [ANCHO-1:0] pc_siguiente;
  logic [ANCHO-1:0] addr_q;

  registro_pc #(
    .ANCHO    (ANCHO),
    .RESET_PC (RESET_PC)
  ) u_registro_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .salto_valido  (salto_valido),
    .salto_destino (salto_destino),
    .incrementar   (incrementar),
    .pc            (pc),
    .pc_inc        (pc_inc),
    .pc_siguiente  (pc_siguiente)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      estado <= INICIO;
    else
      estado <= estado_sig;
  end

  // Every entry into PEDIR latches the address of the new request.
  always_comb begin
    estado_sig     = estado;
    incrementar    = 1'b0;
    capturar       = 1'b0;
    cargar_addr    = 1'b0;
    limpiar_valido = salto_valido;
    case (estado)
      INICIO: begin
        estado_sig  = PEDIR;
        cargar_addr = 1'b1;
      end
      PEDIR: begin
        if (imem_ack) begin
          if (salto_valido) begin
            estado_sig  = PEDIR;
            cargar_addr = 1'b1;
          end else begin
            estado_sig  = ENTREGA;
            incrementar = 1'b1;
            capturar    = 1'b1;
          end
        end else if (salto_valido) begin
          estado_sig = DESCARTAR;
        end
      end
      DESCARTAR: begin
        if (imem_ack) begin
          estado_sig  = PEDIR;
          cargar_addr = 1'b1;
        end
      end
      ENTREGA: begin
        if (salto_valido || !stall) begin
          estado_sig     = PEDIR;
          cargar_addr    = 1'b1;
          limpiar_valido = 1'b1;
        end
      end
      default: estado_sig = INICIO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      instr   <= '0;
      pc_out  <= '0;
      pc_mas4 <= '0;
      valido  <= 1'b0;
    end else begin
      if (cargar_addr)
        addr_q <= pc_siguiente;
      if (capturar) begin
        instr   <= imem_dato;
        pc_out  <= pc;
        pc_mas4 <= pc_inc;
        valido  <= 1'b1;
      end else if (limpiar_valido) begin
        valido <= 1'b0;
      end
    end
  end

  assign imem_req  = (estado == PEDIR) || (estado == DESCARTAR);
  assign imem_addr = addr_q;

endmodule
